// File: rtl/shift_rotate_if.sv
// Operand/result bundle for shift_rotate_unit. Both sides use a valid/ready handshake.
// The master drives operands and out_ready. The slave is the unit itself.
interface shift_rotate_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [1:0]       state;

  modport master (
    output in_valid, mode, A, B, out_ready,
    input  in_ready, out_valid, result, zero, state
  );

  modport slave (
    input  in_valid, mode, A, B, out_ready,
    output in_ready, out_valid, result, zero, state
  );
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-cycle barrel shifter/rotator. It applies one power-of-two stage per clock
// and supports ROR, ROL, logical SHR and arithmetic SHRA at any power-of-two WIDTH.
module shift_rotate_unit #(
  parameter  int WIDTH = 32,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input logic          clock,
  input logic          clear,
  shift_rotate_if.slave bus
);
  localparam int KW = $clog2(LOG2W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] M_ROR  = 2'b00;
  localparam logic [1:0] M_ROL  = 2'b01;
  localparam logic [1:0] M_SHR  = 2'b10;

  localparam logic [KW-1:0]    K_LAST  = KW'(LOG2W - 1);
  localparam logic [LOG2W:0]   W_L     = (LOG2W + 1)'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [LOG2W-1:0] amt_q,   amt_d;
  logic [1:0]       mode_q,  mode_d;
  logic [KW-1:0]    k_q,     k_d;
  logic             zero_q,  zero_d;

  logic [LOG2W:0]   sh;
  logic [WIDTH-1:0] stage_out;
  logic             oversize;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE. out_valid is high only in DONE. Both come straight
  // from state_q, so no input reaches an output combinationally.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = data_q;
  assign bus.zero      = zero_q;
  assign bus.state     = state_q;

  assign oversize = ((bus.B >> LOG2W) != '0);

  always_comb begin
    sh        = (LOG2W + 1)'(1) << k_q;
    stage_out = data_q;
    case (mode_q)
      M_ROR:   stage_out = (data_q >> sh) | (data_q << (W_L - sh));
      M_ROL:   stage_out = (data_q << sh) | (data_q >> (W_L - sh));
      M_SHR:   stage_out = data_q >> sh;
      default: stage_out = WIDTH'($signed(data_q) >>> sh);
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    k_d     = k_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.mode;
          amt_d   = bus.B[LOG2W-1:0];
          k_d     = '0;
          state_d = ST_RUN;
          // An oversized shift loads its fill value now. The stages then move nothing.
          if (bus.mode[1] && oversize) begin
            data_d = bus.mode[0] ? {WIDTH{bus.A[WIDTH-1]}} : '0;
            amt_d  = '0;
          end else begin
            data_d = bus.A;
          end
        end
      end
      ST_RUN: begin
        data_d = amt_q[k_q] ? stage_out : data_q;
        k_d    = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
          zero_d  = (data_d == '0);
          k_d     = '0;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      k_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit at WIDTH=32 and WIDTH=8, plus short random runs
// checked against a bit-by-bit reference model.
module tb_shift_rotate_unit;
  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  shift_rotate_if #(.WIDTH(32)) b32 ();
  shift_rotate_if #(.WIDTH(8))  b8  ();

  shift_rotate_unit #(.WIDTH(32)) dut32 (.clock(clock), .clear(clear), .bus(b32));
  shift_rotate_unit #(.WIDTH(8))  dut8  (.clock(clock), .clear(clear), .bus(b8));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] msk(input int w, input logic [63:0] v);
    return (w == 64) ? v : (v & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic logic ov(input int w);
    return (w == 8) ? b8.out_valid : b32.out_valid;
  endfunction

  function automatic logic ir(input int w);
    return (w == 8) ? b8.in_ready : b32.in_ready;
  endfunction

  function automatic logic [63:0] res(input int w);
    return (w == 8) ? 64'(b8.result) : 64'(b32.result);
  endfunction

  function automatic logic zr(input int w);
    return (w == 8) ? b8.zero : b32.zero;
  endfunction

  function automatic logic [63:0] ref_model(input int w, input logic [1:0] m,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int          n;
    r = '0;
    if (m[1] == 1'b0) begin
      n = int'(b % 64'(w));
      for (int i = 0; i < w; i++)
        r[i] = (m[0] == 1'b0) ? a[(i + n) % w] : a[(i - n + w) % w];
    end else begin
      for (int i = 0; i < w; i++) begin
        if (b >= 64'(w) || (i + int'(b)) >= w) r[i] = m[0] ? a[w-1] : 1'b0;
        else                                  r[i] = a[i + int'(b)];
      end
    end
    return r;
  endfunction

  task automatic issue(input int w, input logic [1:0] m, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    int waited;
    waited = 0;
    while (!ir(w) && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    chk({tag, " ready_before_issue"}, 64'(ir(w)), 64'd1);
    if (w == 8) begin
      b8.in_valid = 1'b1; b8.mode = m; b8.A = a[7:0]; b8.B = b[7:0];
    end else begin
      b32.in_valid = 1'b1; b32.mode = m; b32.A = a[31:0]; b32.B = b[31:0];
    end
    @(posedge clock); #1;
    b8.in_valid  = 1'b0;
    b32.in_valid = 1'b0;
  endtask

  // Called at #1 after the accept edge. out_valid must appear exactly LOG2W edges later.
  task automatic wait_done(input int w, input logic [63:0] exp_r, input string tag);
    int lat;
    lat = (w == 8) ? 3 : 5;
    for (int i = 0; i < lat; i++) begin
      chk({tag, " early_out_valid"}, 64'(ov(w)), 64'd0);
      @(posedge clock); #1;
    end
    chk({tag, " out_valid"}, 64'(ov(w)), 64'd1);
    chk({tag, " result"}, res(w), msk(w, exp_r));
    chk({tag, " zero"}, 64'(zr(w)), 64'(msk(w, exp_r) == 64'd0));
  endtask

  task automatic release_out(input int w, input string tag);
    b8.out_ready = 1'b1; b32.out_ready = 1'b1;
    @(posedge clock); #1;
    b8.out_ready = 1'b0; b32.out_ready = 1'b0;
    chk({tag, " idle_in_ready"}, 64'(ir(w)), 64'd1);
    chk({tag, " idle_out_valid"}, 64'(ov(w)), 64'd0);
  endtask

  task automatic run_op(input int w, input logic [1:0] m, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_r, input string tag);
    issue(w, m, a, b, tag);
    wait_done(w, exp_r, tag);
    release_out(w, tag);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  rm;
    b32.in_valid = 1'b0; b32.mode = 2'b00; b32.A = '0; b32.B = '0; b32.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.mode  = 2'b00; b8.A  = '0; b8.B  = '0; b8.out_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst in_ready",  64'(b32.in_ready), 64'd1);
    chk("rst out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst result",    64'(b32.result), 64'd0);
    chk("rst zero",      64'(b32.zero), 64'd1);
    clear = 1'b1;
    @(posedge clock); #1;

    // Directed WIDTH=32 vectors
    run_op(32, 2'b00, 64'h000000F1, 64'd4,   64'h1000000F, "ror32_f1_4");
    run_op(32, 2'b01, 64'h80000001, 64'd1,   64'h00000003, "rol32_1");
    run_op(32, 2'b00, 64'h00000003, 64'd33,  64'h80000001, "ror32_wrap33");
    run_op(32, 2'b00, 64'hDEADBEEF, 64'd0,   64'hDEADBEEF, "ror32_b0");
    run_op(32, 2'b11, 64'h80000000, 64'd31,  64'hFFFFFFFF, "shra32_31");
    run_op(32, 2'b11, 64'h80000000, 64'd40,  64'hFFFFFFFF, "shra32_40");
    run_op(32, 2'b10, 64'h80000000, 64'd32,  64'h00000000, "shr32_32");
    run_op(32, 2'b11, 64'h40000000, 64'd100, 64'h00000000, "shra32_100");
    run_op(32, 2'b10, 64'hF0000000, 64'd4,   64'h0F000000, "shr32_4");
    run_op(32, 2'b01, 64'h12345678, 64'd40,  64'h34567812, "rol32_40");

    // Backpressure: hold DONE for three cycles while a new request is ignored
    issue(32, 2'b01, 64'h0000F00F, 64'd8, "bp");
    wait_done(32, 64'h00F00F00, "bp");
    b32.in_valid = 1'b1; b32.mode = 2'b10; b32.A = 32'hFFFFFFFF; b32.B = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("bp hold out_valid", 64'(b32.out_valid), 64'd1);
      chk("bp hold result",    64'(b32.result), 64'h00F00F00);
      chk("bp hold zero",      64'(b32.zero), 64'd0);
      chk("bp hold in_ready",  64'(b32.in_ready), 64'd0);
    end
    b32.in_valid = 1'b0;
    release_out(32, "bp");

    // Reset during RUN discards the operation
    issue(32, 2'b00, 64'h0000FFFF, 64'd5, "rstmid");
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    chk("rstmid in_ready",  64'(b32.in_ready), 64'd1);
    chk("rstmid out_valid", 64'(b32.out_valid), 64'd0);
    chk("rstmid result",    64'(b32.result), 64'd0);
    chk("rstmid zero",      64'(b32.zero), 64'd1);
    @(posedge clock); #1;
    clear = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      chk("rstmid no_out_valid", 64'(b32.out_valid), 64'd0);
    end
    run_op(32, 2'b00, 64'h0000FFFF, 64'd4, 64'hF0000FFF, "after_rst");

    // WIDTH=8 vectors
    run_op(8, 2'b00, 64'h81, 64'd1,  64'hC0, "ror8_1");
    run_op(8, 2'b11, 64'h80, 64'd9,  64'hFF, "shra8_9");
    run_op(8, 2'b01, 64'h81, 64'd3,  64'h0C, "rol8_3");
    run_op(8, 2'b10, 64'hF0, 64'd8,  64'h00, "shr8_8");
    run_op(8, 2'b11, 64'h90, 64'd2,  64'hE4, "shra8_2");

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = {32'd0, $urandom()};
      rb = 64'($urandom_range(0, 70));
      run_op(32, rm, ra, rb, ref_model(32, rm, msk(32, ra), rb), "rand32");
    end
    for (int i = 0; i < 12; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 20));
      run_op(8, rm, ra, rb, ref_model(8, rm, ra, rb), "rand8");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
